peri_ctrl: RTL and testbench

Memory-mapped peripheral controller directly downstream of the CPU core's MEM stage. It decodes the shared data-bus address, provides a combinational read port and synchronous write port for a programmable timer, LED, switch, 7-segment and system-tick registers, and raises the interrupt request that the CPU's PC, control and register-file logic consume.

---
 rtl/peri_ctrl_pkg.sv | 53 +++++
 rtl/peri_timer.sv | 57 +++++
 rtl/peri_ctrl.sv | 98 +++++++++
 tb/tb_peri_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/peri_ctrl_pkg.sv
// Shared definitions for the memory-mapped peripheral block: bus widths,
// register offsets, TCON bit positions and the address decoder.
package peri_ctrl_pkg;

  localparam int unsigned MEM_BUS      = 32;
  localparam int unsigned MEM_ADDR_BUS = 32;

  localparam logic [MEM_ADDR_BUS-1:0] PERI_BASE = 32'h4000_0000;

  localparam logic [7:0] ADDR_TH      = 8'h00;
  localparam logic [7:0] ADDR_TL      = 8'h04;
  localparam logic [7:0] ADDR_TCON    = 8'h08;
  localparam logic [7:0] ADDR_LED     = 8'h0C;
  localparam logic [7:0] ADDR_SWITCH  = 8'h10;
  localparam logic [7:0] ADDR_DIGI    = 8'h14;
  localparam logic [7:0] ADDR_SYSTICK = 8'h18;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;
  localparam int unsigned TCON_W  = 3;

  localparam int unsigned LED_W = 8;
  localparam int unsigned SW_W  = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SWITCH,
    SEL_DIGI,
    SEL_SYSTICK
  } reg_sel_e;

  // Byte-lane bits are masked off so any address within a word selects it.
  function automatic reg_sel_e decode_addr(input logic [MEM_ADDR_BUS-1:0] a);
    logic [MEM_ADDR_BUS-1:0] w;
    w = a & ~MEM_ADDR_BUS'(3);
    case (w)
      PERI_BASE + MEM_ADDR_BUS'(ADDR_TH):      decode_addr = SEL_TH;
      PERI_BASE + MEM_ADDR_BUS'(ADDR_TL):      decode_addr = SEL_TL;
      PERI_BASE + MEM_ADDR_BUS'(ADDR_TCON):    decode_addr = SEL_TCON;
      PERI_BASE + MEM_ADDR_BUS'(ADDR_LED):     decode_addr = SEL_LED;
      PERI_BASE + MEM_ADDR_BUS'(ADDR_SWITCH):  decode_addr = SEL_SWITCH;
      PERI_BASE + MEM_ADDR_BUS'(ADDR_DIGI):    decode_addr = SEL_DIGI;
      PERI_BASE + MEM_ADDR_BUS'(ADDR_SYSTICK): decode_addr = SEL_SYSTICK;
      default:                                 decode_addr = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/peri_timer.sv
// Programmable reload timer: TH/TL/TCON registers, overflow reload,
// interrupt-status set and CPU-write priority over hardware updates.
module peri_timer
  import peri_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_th,
  input  logic               we_tl,
  input  logic               we_tcon,
  input  logic [TIMER_W-1:0] wdata_timer,
  input  logic [TCON_W-1:0]  wdata_tcon,
  output logic [TIMER_W-1:0] th,
  output logic [TIMER_W-1:0] tl,
  output logic [TCON_W-1:0]  tcon
);

  logic wrap;

  assign wrap = tcon[TCON_EN] && (tl == '1);

  // Reload samples the pre-edge TH, so a TH write in the wrap cycle
  // only affects the next period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th <= '0;
    end else if (we_th) begin
      th <= wdata_timer;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tl <= '0;
    end else if (we_tl) begin
      tl <= wdata_timer;
    end else if (wrap) begin
      tl <= th;
    end else if (tcon[TCON_EN]) begin
      tl <= tl + 1'b1;
    end
  end

  // A CPU write overrides a same-cycle status set so an ISR clear is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcon <= '0;
    end else if (we_tcon) begin
      tcon <= wdata_tcon;
    end else if (wrap && tcon[TCON_IE]) begin
      tcon[TCON_IS] <= 1'b1;
    end
  end

endmodule

// File: rtl/peri_ctrl.sv
// Memory-mapped peripheral controller on the MEM-stage data bus: address
// decode, combinational reads, LED/DIGI/SWITCH/SYSTICK and the timer IRQ.
module peri_ctrl
  import peri_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_W = 32,
  parameter int unsigned DIGI_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cre,
  input  logic                    cwe,
  input  logic [MEM_ADDR_BUS-1:0] addr,
  input  logic [MEM_BUS-1:0]      wdata,
  input  logic                    pc31,
  input  logic [SW_W-1:0]         switch_i,
  output logic [MEM_BUS-1:0]      rdata,
  output logic                    intreq,
  output logic [LED_W-1:0]        led_o,
  output logic [DIGI_W-1:0]       digi_o
);

  reg_sel_e           sel;
  logic [TIMER_W-1:0] th;
  logic [TIMER_W-1:0] tl;
  logic [TCON_W-1:0]  tcon;
  logic [TIMER_W-1:0] systick;
  logic [SW_W-1:0]    sw_meta;
  logic [SW_W-1:0]    sw_sync;
  logic [LED_W-1:0]   led;
  logic [DIGI_W-1:0]  digi;

  assign sel = decode_addr(addr);

  peri_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst),
    .we_th       (cwe && (sel == SEL_TH)),
    .we_tl       (cwe && (sel == SEL_TL)),
    .we_tcon     (cwe && (sel == SEL_TCON)),
    .wdata_timer (wdata[TIMER_W-1:0]),
    .wdata_tcon  (wdata[TCON_W-1:0]),
    .th          (th),
    .tl          (tl),
    .tcon        (tcon)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led  <= '0;
      digi <= '0;
    end else if (cwe) begin
      if (sel == SEL_LED)  led  <= wdata[LED_W-1:0];
      if (sel == SEL_DIGI) digi <= wdata[DIGI_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_i;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      systick <= '0;
    end else begin
      systick <= systick + 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (cre) begin
      case (sel)
        SEL_TH:      rdata = MEM_BUS'(th);
        SEL_TL:      rdata = MEM_BUS'(tl);
        SEL_TCON:    rdata = MEM_BUS'(tcon);
        SEL_LED:     rdata = MEM_BUS'(led);
        SEL_SWITCH:  rdata = MEM_BUS'(sw_sync);
        SEL_DIGI:    rdata = MEM_BUS'(digi);
        SEL_SYSTICK: rdata = MEM_BUS'(systick);
        default:     rdata = '0;
      endcase
    end
  end

  assign intreq = tcon[TCON_IS] & tcon[TCON_IE] & ~pc31;
  assign led_o  = led;
  assign digi_o = digi;

endmodule

// File: tb/tb_peri_ctrl.sv
// Directed bench for peri_ctrl: register map, timer reload/IRQ, write
// collisions, switch synchroniser and asynchronous reset.
module tb_peri_ctrl;

  logic        clk;
  logic        rst;
  logic        cre;
  logic        cwe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        pc31;
  logic [7:0]  switch_i;
  logic [31:0] rdata;
  logic        intreq;
  logic [7:0]  led_o;
  logic [11:0] digi_o;

  int unsigned total;
  int unsigned passes;
  logic [31:0] snap;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;

  peri_ctrl #(
    .TIMER_W (32),
    .DIGI_W  (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cre      (cre),
    .cwe      (cwe),
    .addr     (addr),
    .wdata    (wdata),
    .pc31     (pc31),
    .switch_i (switch_i),
    .rdata    (rdata),
    .intreq   (intreq),
    .led_o    (led_o),
    .digi_o   (digi_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    cre  = 1'b1;
    #1;
    d    = rdata;
    cre  = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    cwe   = 1'b1;
    @(posedge clk);
    #1;
    cwe   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; passes = 0;
    rst = 1'b0; cre = 1'b0; cwe = 1'b0; addr = '0; wdata = '0;
    pc31 = 1'b0; switch_i = '0;

    // reset state: reads issued while reset is held
    for (int unsigned i = 0; i < 7; i++) begin
      chk_rd($sformatf("reset_rd_%0d", i), A_TH + 32'(i * 4), 32'h0);
    end
    chk_rd("unmapped_1c", 32'h4000_001C, 32'h0);
    chk_rd("foreign_addr", 32'h1000_0000, 32'h0);
    check("reset_intreq", {31'h0, intreq}, 32'h0);
    check("reset_led", {24'h0, led_o}, 32'h0);
    check("reset_digi", {20'h0, digi_o}, 32'h0);

    step();
    rst = 1'b1;

    // timer interrupt
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_TCON, 32'h3);
    step(); step(); step();
    chk_rd("tl_before_wrap", A_TL, 32'hFFFF_FFFF);
    check("intreq_before_wrap", {31'h0, intreq}, 32'h0);
    step();
    chk_rd("tl_reloaded", A_TL, 32'hFFFF_FFFC);
    chk_rd("tcon_status", A_TCON, 32'h7);
    check("intreq_user", {31'h0, intreq}, 32'h1);
    pc31 = 1'b1;
    #1;
    check("intreq_kernel_masked", {31'h0, intreq}, 32'h0);
    pc31 = 1'b0;
    wr(A_TCON, 32'h3);
    check("intreq_cleared", {31'h0, intreq}, 32'h0);
    chk_rd("tcon_after_clear", A_TCON, 32'h3);
    chk_rd("tl_keeps_counting", A_TL, 32'hFFFF_FFFD);

    // TCON write on the overflow edge
    wr(A_TL, 32'hFFFF_FFFF);
    chk_rd("tl_write_wins", A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    chk_rd("collide_tcon", A_TCON, 32'h3);
    chk_rd("collide_tl_eq_th", A_TL, 32'hFFFF_FFFC);
    check("collide_intreq", {31'h0, intreq}, 32'h0);

    // TH write on the overflow edge reloads the old TH
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h0000_0100);
    chk_rd("th_collide_tl_old_th", A_TL, 32'hFFFF_FFFC);
    chk_rd("th_collide_th_new", A_TH, 32'h0000_0100);
    chk_rd("th_collide_tcon", A_TCON, 32'h7);
    wr(A_TCON, 32'h0);
    wr(A_TL, 32'h0000_0000);
    step();
    chk_rd("tl_holds_disabled", A_TL, 32'h0);

    // LED / DIGI
    wr(A_LED, 32'hFFFF_FFA5);
    check("led_o", {24'h0, led_o}, 32'hA5);
    chk_rd("led_rd_zext", A_LED, 32'hA5);
    wr(A_DIGI, 32'h0000_03F1);
    check("digi_o", {20'h0, digi_o}, 32'h3F1);
    chk_rd("digi_rd", A_DIGI, 32'h3F1);
    addr = A_LED; cre = 1'b0;
    #1;
    check("rdata_cre_low", rdata, 32'h0);

    // simultaneous read and write returns the pre-write value
    addr = A_LED; wdata = 32'h11; cre = 1'b1; cwe = 1'b1;
    #1;
    check("rw_same_cycle_old", rdata, 32'hA5);
    @(posedge clk);
    #1;
    cwe = 1'b0;
    check("rw_same_cycle_new", rdata, 32'h11);
    cre = 1'b0;

    // switch synchroniser
    switch_i = 8'h5A;
    step();
    chk_rd("switch_1_edge", A_SW, 32'h0);
    step();
    chk_rd("switch_2_edges", A_SW, 32'h5A);
    wr(A_SW, 32'h0);
    chk_rd("switch_write_ignored", A_SW, 32'h5A);

    // SYSTICK ignores writes and keeps counting
    rd(A_TICK, snap);
    wr(A_TICK, 32'h0);
    chk_rd("systick_write_ignored", A_TICK, snap + 32'h1);

    // asynchronous reset mid-count
    wr(A_TCON, 32'h1);
    wr(A_TL, 32'h0000_1234);
    chk_rd("pre_reset_tl", A_TL, 32'h1234);
    rst = 1'b0;
    #1;
    chk_rd("async_rst_tl", A_TL, 32'h0);
    chk_rd("async_rst_tcon", A_TCON, 32'h0);
    chk_rd("async_rst_systick", A_TICK, 32'h0);
    check("async_rst_led", {24'h0, led_o}, 32'h0);
    rst = 1'b1;
    step();
    chk_rd("systick_after_release", A_TICK, 32'h1);
    chk_rd("tl_after_release", A_TL, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
